// File: rtl/uart_fifo_pkg.sv
// Shared defaults, read-mode encodings and helpers for the UART FIFO block.
package uart_fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int FWFT_REG  = 0;
  localparam int FWFT_SHOW = 1;

  // almost-full sits this far below DEPTH by default
  localparam int DEF_AF_OFFSET = 2;
  localparam int DEF_AE_THRESH = 2;

  // bit0 = write accepted, bit1 = read accepted
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WR    = 2'b01,
    OP_RD    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  function automatic logic is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // contents are never reset; occupancy tracking guards stale words
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_ext.sv
// Synchronous FIFO with registered or first-word-fall-through read,
// threshold flags, sticky overflow/underflow and synchronous flush.
module uart_fifo_ext
  import uart_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FWFT       = FWFT_REG,
  parameter int AF_THRESH  = FIFO_DEPTH - DEF_AF_OFFSET,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_fifo_wen,
  input  logic                        i_fifo_ren,
  input  logic                        i_fifo_flush,
  input  logic                        i_fifo_clr_err,
  input  logic [FIFO_WIDTH-1:0]       i_fifo_wdata,
  output logic [FIFO_WIDTH-1:0]       o_fifo_rdata,
  output logic                        o_fifo_rvalid,
  output logic                        o_fifo_full,
  output logic                        o_fifo_empty,
  output logic                        o_fifo_afull,
  output logic                        o_fifo_aempty,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic                        o_fifo_ovf,
  output logic                        o_fifo_udf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("uart_fifo_ext: FIFO_WIDTH must be >= 1");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_fifo_ext: FIFO_DEPTH must be a power of two >= 2");
  end
  if (FWFT != FWFT_REG && FWFT != FWFT_SHOW) begin : g_bad_fwft
    $error("uart_fifo_ext: FWFT must be 0 or 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("uart_fifo_ext: AF_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("uart_fifo_ext: AE_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         cnt;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  ovf, udf, ovf_set, udf_set;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  fifo_op_e              op;

  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign empty = (cnt == '0);

  // a write into a full FIFO is allowed when a read frees the slot this cycle
  assign rd_acc = i_fifo_ren & ~empty & ~i_fifo_flush;
  assign wr_acc = i_fifo_wen & (~full | rd_acc) & ~i_fifo_flush;
  assign op     = fifo_op_e'({rd_acc, wr_acc});

  assign ovf_set = i_fifo_wen & ~wr_acc & ~i_fifo_flush;
  assign udf_set = i_fifo_ren & empty & ~i_fifo_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (i_fifo_flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + AW'(1);
        if (rd_acc) rptr <= rptr + AW'(1);
        case (op)
          OP_WR:   cnt <= cnt + CW'(1);
          OP_RD:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
      // a new error in the same cycle as clear wins
      ovf <= ovf_set | (ovf & ~i_fifo_clr_err);
      udf <= udf_set | (udf & ~i_fifo_clr_err);
    end
  end

  uart_fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (i_fifo_wdata),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  if (FWFT == FWFT_SHOW) begin : g_fwft
    assign o_fifo_rdata  = ram_rdata;
    assign o_fifo_rvalid = ~empty;
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // flush blocks rd_acc, so it also drops rvalid and leaves rdata alone
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= ram_rdata;
      end
    end

    assign o_fifo_rdata  = rdata_q;
    assign o_fifo_rvalid = rvalid_q;
  end

  assign o_fifo_full   = full;
  assign o_fifo_empty  = empty;
  assign o_fifo_afull  = (cnt >= CW'(AF_THRESH));
  assign o_fifo_aempty = (cnt <= CW'(AE_THRESH));
  assign o_fifo_cnt    = cnt;
  assign o_fifo_ovf    = ovf;
  assign o_fifo_udf    = udf;

endmodule

// File: doc/uart_fifo_ext.md
UART_FIFO_EXT -- requirements
Module: uart_fifo_ext

Interface
REQ-001 Parameter FIFO_WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter FIFO_DEPTH, default 16: entry count, power of two, at least 2.
REQ-003 Parameter FWFT, default 0: read mode; 0 means registered read, 1 means first-word-fall-through.
REQ-004 Parameter AF_THRESH, default FIFO_DEPTH-2: almost-full level, 1..FIFO_DEPTH.
REQ-005 Parameter AE_THRESH, default 2: almost-empty level, 0..FIFO_DEPTH-1.
REQ-006 Ports: clk  in  1  clock; all state changes on the rising edge.
REQ-007 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-008 Ports: i_fifo_wen  in  1  write request; i_fifo_ren  in  1  read/pop request.
REQ-009 Ports: i_fifo_flush  in  1  synchronous empty; i_fifo_clr_err  in  1  clears the sticky error flags.
REQ-010 Ports: i_fifo_wdata  in  FIFO_WIDTH  write data; o_fifo_rdata  out  FIFO_WIDTH  read data.
REQ-011 Ports: o_fifo_rvalid  out  1  read-data-valid strobe.
REQ-012 Ports: o_fifo_full, o_fifo_empty, o_fifo_afull, o_fifo_aempty  out  1 each  status flags.
REQ-013 Ports: o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy; o_fifo_ovf, o_fifo_udf  out  1 each  sticky overflow and underflow flags.

Function
REQ-014 Write accept condition: wen && (!full || read accepted in the same cycle) && !flush.
REQ-015 Read accept condition: ren && !empty && !flush.
- A read never consumes the word written in the same cycle.
REQ-016 Occupancy update on each accepted operation:
- write only: cnt+1
- read only: cnt-1
- both: cnt unchanged
- cnt never exceeds FIFO_DEPTH and never goes below 0.
REQ-017 Pointers:
- wptr and rptr are $clog2(FIFO_DEPTH) bits wide.
- each advances by 1 on its accepted operation.
- each wraps naturally from FIFO_DEPTH-1 to 0.
REQ-018 Status flags, all combinational from cnt:
- full = (cnt==FIFO_DEPTH)
- empty = (cnt==0)
- afull = (cnt>=AF_THRESH)
- aempty = (cnt<=AE_THRESH)
REQ-019 FWFT=0 read behaviour:
- rdata is registered from buffer[rptr] on an accepted read.
- rvalid is high for exactly the next cycle.
- rdata holds its value otherwise.
REQ-020 FWFT=1 read behaviour:
- rdata continuously shows buffer[rptr].
- rvalid = !empty.
- an accepted read pops that word; the next word appears in the same cycle the pointer advances.
REQ-021 Overflow: ovf is set on the cycle after wen is asserted and the write is rejected because the FIFO is full.
REQ-022 Underflow: udf is set on the cycle after ren is asserted while empty.
- This includes a simultaneous write into an empty FIFO: the write is accepted and the read is rejected.
REQ-023 Error clear:
- clr_err clears ovf and udf.
- if a new error occurs in the same cycle, set wins.
REQ-024 Flush:
- zeroes wptr, rptr and cnt.
- has priority over wen and ren in the same cycle; neither is accepted and neither sets an error flag.
- does not alter ovf, udf or the FWFT=0 rdata register.
- forces rvalid low on the next cycle.
REQ-025 Storage contents are not cleared by reset or flush; words read after a flush are only ever newly written data.

Reset
REQ-026 While rst_n is low, regardless of clk:
- wptr=0, rptr=0, cnt=0
- rdata=0, rvalid=0
- ovf=0, udf=0
REQ-027 After reset: empty=1, full=0, aempty=1, afull=0 (with AF_THRESH>=1).
REQ-028 Reset asserted mid-operation discards all contents and any in-flight rvalid.
REQ-029 Reset is released synchronously to clk by the system; the block takes no further action for reset release.

Structure
REQ-030 Package uart_fifo_pkg SHALL hold the shared parameter defaults:
- default FIFO_WIDTH and FIFO_DEPTH
- FWFT mode encodings
- default threshold offsets
REQ-031 Storage SHALL be one sub-module, uart_fifo_ram:
- one synchronous write port.
- one asynchronous read port, addressed by rptr.
- the register-mode rdata flop lives in uart_fifo_ext.
REQ-032 Parameter legality (power-of-two depth, threshold ranges) SHALL be checked at elaboration.

Verification
REQ-033 Defaults, FWFT=0: write 0x11, 0x22, 0x33, then 3 reads on consecutive cycles -> rvalid high 3 cycles, rdata 0x11, 0x22, 0x33 in order, cnt 3→0, empty=1.
REQ-034 Fill and overflow: 16 writes -> full=1, afull=1 from cnt=14; a 17th write is rejected -> ovf=1, cnt=16, contents intact; clr_err -> ovf=0.
REQ-035 Simultaneous operations:
- full FIFO, wen+ren together -> both accepted, cnt=16, oldest word out.
- empty FIFO, wen+ren together -> cnt=1, udf=1, rvalid=0.
REQ-036 FWFT=1: write 0xA5 -> rdata=0xA5 and rvalid=1 the next cycle with no ren; ren -> empty=1, rvalid=0.
REQ-037 Wrap-around: 40 interleaved writes and reads of an incrementing pattern keeping cnt between 1 and 5 -> output sequence matches input exactly.
REQ-038 Flush and reset:
- flush with cnt=7 and wen+ren asserted -> cnt=0, empty=1, no error flags set.
- rst_n pulsed low mid-burst -> all reset values of REQ-026 appear immediately.
